rgb_gray_stream: RTL and testbench
==================================

// Module: rgb_gray_stream
// PURPOSE
//  Parametrised RGB-to-grayscale stream converter with valid/ready handshake and SOP/EOP framing.
//  Sits between the image buffer and pattern_recognition, replacing fixed inline RGB444 averaging.
//  Adds run-time conversion modes, backpressure, frame-boundary mode latching and frame-length checking.
// PARAMETERS
//  CH_W        4    bits per input colour channel (R,G,B packed {R,G,B}, R in MSBs)
//  OUT_W       8    output gray width; each channel is expanded to OUT_W by bit replication before arithmetic
//  IMG_WIDTH   640  pixels per line
//  IMG_HEIGHT  480  lines per frame; expected pixels/frame NPIX = IMG_WIDTH*IMG_HEIGHT
//  FCNT_W      16   frame counter width
// PORTS
//  clk          in   1          video clock
//  rst_n        in   1          synchronous active-low reset
//  mode         in   2          0=avg, 1=luma, 2=green, 3=max; sampled only at an accepted SOP
//  x_valid      in   1          input pixel valid
//  x_ready      out  1          converter can accept the input pixel
//  x_data       in   3*CH_W     {R,G,B} pixel
//  x_sop        in   1          first pixel of frame (qualified by x_valid&x_ready)
//  x_eop        in   1          last pixel of frame
//  y_valid      out  1          output gray pixel valid
//  y_ready      in   1          downstream accepts the output pixel
//  y_data       out  OUT_W      gray pixel
//  y_sop        out  1          SOP aligned with y_data
//  y_eop        out  1          EOP aligned with y_data
//  frame_count  out  FCNT_W     number of accepted input EOPs, wraps modulo 2^FCNT_W
//  frame_error  out  1          sticky: a framing violation has been seen since reset
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): both pipe stages empty; y_valid,y_sop,y_eop,frame_error=0; y_data=0;
//   frame_count=0; pixel counter=0; active mode=0 (avg); x_ready=0 while rst_n=0.
//  Handshake: transfer when valid&ready at a clk edge. y_data/y_sop/y_eop stay stable while y_valid&~y_ready.
//  Pipeline: 2 registered stages. S1 holds expanded channels + active mode; S2 holds y_data.
//   s2_ready = ~s2_valid | y_ready;  x_ready = rst_n & (~s1_valid | s2_ready)  (combinational).
//   Latency 2 cycles accept->y_valid; throughput 1 pixel/clk when y_ready=1; no loss or duplication
//   under any y_ready pattern; at most 2 pixels buffered.
//  Expansion: e = CH_W bits replicated MSB-first and truncated to OUT_W (CH_W=4: 0xA -> 0xAA).
//  Arithmetic (S1->S2, unsigned, no overflow, intermediate width OUT_W+10):
//   avg  : floor((eR+eG+eB)/3), exact
//   luma : (77*eR + 150*eG + 29*eB) >> 8
//   green: eG
//   max  : max(eR,eG,eB)
//  Mode latching: mode sampled on accepted pixel with x_sop=1 and applied to that pixel and all of its frame;
//   mode changes between SOPs have no effect.
//  Frame checking (on accepted input pixels): pixel counter := 1 on SOP, else +1 (saturates at NPIX+1).
//   frame_error set if: EOP with counter != NPIX; SOP while counter in 1..NPIX-1 (frame not closed);
//   non-SOP pixel while counter==0 or frame already closed. Pixels still pass through unmodified.
//  EOP accepted: frame_count+1 (wraps), counter marked closed. SOP and EOP on the same pixel is valid
//   only when NPIX==1.
//  Reset mid-frame: pipeline contents discarded; next frame must start with SOP.
// STRUCTURE
//  video_pkg: gray_mode_e enum {GRAY_AVG, GRAY_LUMA, GRAY_GREEN, GRAY_MAX}; LUMA_KR/KG/KB = 77/150/29.
//  Sub-module gray_kernel: combinational expand+mode arithmetic (CH_W, OUT_W params), instanced between S1 and S2.
//  Top body: two elastic pipe registers, mode latch, pixel/frame counters, error logic.
// TESTING
//  Defaults, mode=0, x=0xFFF then 0x840, y_ready=1 -> y_data 0xFF then 0x44, each 2 cycles after accept.
//  mode=1 x=0x0F0 -> 0x95; mode=2 x=0x3A5 -> 0xAA; mode=3 x=0x3A5 -> 0xAA; mode=3 x=0x000 -> 0x00.
//  Stream 20 pixels, y_ready low for 5 cycles mid-burst -> x_ready drops once 2 held; output order/values intact.
//  IMG 4x2: mode=0 at SOP, mode=1 on pixel 3 -> all 8 pixels avg-converted; frame_count=1; frame_error=0.
//  IMG 4x2: EOP on pixel 6 -> frame_error=1 and stays 1; frame_count=1; next SOP frame converts normally.
//  Reset asserted with 2 pixels buffered -> y_valid=0, frame_count=0, frame_error=0 next cycle, x_ready=0 during reset.

Source files
------------

// File: rtl/rgb_gray_stream_pkg.sv
// Shared definitions for the RGB-to-grayscale stream converter.
//   gray_mode_e : run-time conversion mode encoding (matches the 2-bit mode port)
//   LUMA_K*     : 8-bit fixed-point luma weights, sum = 256
package rgb_gray_stream_pkg;

    typedef enum logic [1:0] {
        GRAY_AVG   = 2'd0,
        GRAY_LUMA  = 2'd1,
        GRAY_GREEN = 2'd2,
        GRAY_MAX   = 2'd3
    } gray_mode_e;

    localparam int LUMA_KR    = 77;
    localparam int LUMA_KG    = 150;
    localparam int LUMA_KB    = 29;
    localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/rgb_gray_stream_gray_kernel.sv
// gray_kernel: combinational pixel converter.
//   rgb  in  3*CH_W  {R,G,B} pixel, R in the MSBs
//   mode in  2       conversion mode (gray_mode_e)
//   gray out OUT_W   gray value
// Each channel is widened to OUT_W by MSB-first bit replication, then the
// selected mode is evaluated in an OUT_W+10 bit unsigned accumulator.
module gray_kernel
    import rgb_gray_stream_pkg::*;
#(
    parameter int CH_W  = 4,
    parameter int OUT_W = 8
) (
    input  logic [3*CH_W-1:0] rgb,
    input  gray_mode_e        mode,
    output logic [OUT_W-1:0]  gray
);

    localparam int ACC_W = OUT_W + 10;

    logic [OUT_W-1:0] e_r;
    logic [OUT_W-1:0] e_g;
    logic [OUT_W-1:0] e_b;

    // Repeat the channel bits from the MSB down until OUT_W bits are filled,
    // so full-scale input maps to full-scale output (0xA -> 0xAA).
    function automatic logic [OUT_W-1:0] expand(input logic [CH_W-1:0] c);
        logic [OUT_W-1:0] e;
        e = '0;
        for (int i = 0; i < OUT_W; i++) begin
            e[OUT_W-1-i] = c[CH_W-1-(i % CH_W)];
        end
        return e;
    endfunction

    // Exact floor division of the three-channel sum.
    function automatic logic [OUT_W-1:0] avg3(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b,
                                              input logic [OUT_W-1:0] c);
        logic [ACC_W-1:0] sum;
        logic [ACC_W-1:0] quo;
        sum = ACC_W'(a) + ACC_W'(b) + ACC_W'(c);
        quo = sum / ACC_W'(3);
        return quo[OUT_W-1:0];
    endfunction

    // Weighted sum truncated back to OUT_W; weights sum to 256 so no overflow.
    function automatic logic [OUT_W-1:0] luma(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b,
                                              input logic [OUT_W-1:0] c);
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(LUMA_KR) * ACC_W'(a)
            + ACC_W'(LUMA_KG) * ACC_W'(b)
            + ACC_W'(LUMA_KB) * ACC_W'(c);
        return acc[LUMA_SHIFT +: OUT_W];
    endfunction

    function automatic logic [OUT_W-1:0] max3(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b,
                                              input logic [OUT_W-1:0] c);
        logic [OUT_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    assign e_r = expand(rgb[3*CH_W-1:2*CH_W]);
    assign e_g = expand(rgb[2*CH_W-1:CH_W]);
    assign e_b = expand(rgb[CH_W-1:0]);

    always_comb begin
        gray = '0;
        case (mode)
            GRAY_AVG:   gray = avg3(e_r, e_g, e_b);
            GRAY_LUMA:  gray = luma(e_r, e_g, e_b);
            GRAY_GREEN: gray = e_g;
            GRAY_MAX:   gray = max3(e_r, e_g, e_b);
            default:    gray = '0;
        endcase
    end

endmodule

// File: rtl/rgb_gray_stream.sv
// rgb_gray_stream: RGB-to-grayscale stream converter, valid/ready with SOP/EOP.
//   clk, rst_n          clock, synchronous active-low reset
//   mode                conversion mode, latched on each accepted SOP pixel
//   x_valid/x_ready     input handshake; x_data {R,G,B}, x_sop, x_eop
//   y_valid/y_ready     output handshake; y_data gray, y_sop, y_eop
//   frame_count         accepted input EOPs, wrapping
//   frame_error         sticky framing-violation flag
// Two elastic register stages: p1 holds the raw pixel with its effective mode,
// p2 holds the converted gray value. Up to two pixels are buffered.
module rgb_gray_stream
    import rgb_gray_stream_pkg::*;
#(
    parameter int CH_W       = 4,
    parameter int OUT_W      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [3*CH_W-1:0] x_data,
    input  logic              x_sop,
    input  logic              x_eop,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [OUT_W-1:0]  y_data,
    output logic              y_sop,
    output logic              y_eop,
    output logic [FCNT_W-1:0] frame_count,
    output logic              frame_error
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_NPIX = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NPIX + 1);

    logic              vld_p1;
    logic [3*CH_W-1:0] pix_p1;
    gray_mode_e        mode_p1;
    logic              sop_p1;
    logic              eop_p1;

    logic              vld_p2;
    logic [OUT_W-1:0]  gray_p2;
    logic              sop_p2;
    logic              eop_p2;

    logic              s2_ready;
    logic              x_acc;
    gray_mode_e        active_mode;
    gray_mode_e        pix_mode;
    logic [OUT_W-1:0]  gray_k;

    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              closed;
    logic              err_now;

    assign s2_ready = ~vld_p2 | y_ready;
    assign x_ready  = rst_n & (~vld_p1 | s2_ready);
    assign x_acc    = x_valid & x_ready;

    // An SOP pixel uses the mode presented with it; every other pixel uses
    // the mode captured at the most recent SOP.
    assign pix_mode = x_sop ? gray_mode_e'(mode) : active_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_mode <= GRAY_AVG;
        end else if (x_acc && x_sop) begin
            active_mode <= gray_mode_e'(mode);
        end
    end

    // ---- input -> p1 ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (~vld_p1 | s2_ready) begin
            vld_p1 <= x_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (x_acc) begin
            pix_p1  <= x_data;
            mode_p1 <= pix_mode;
            sop_p1  <= x_sop;
            eop_p1  <= x_eop;
        end
    end

    gray_kernel #(
        .CH_W  (CH_W),
        .OUT_W (OUT_W)
    ) u_kernel (
        .rgb  (pix_p1),
        .mode (mode_p1),
        .gray (gray_k)
    );

    // ---- p1 -> p2 ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            gray_p2 <= '0;
            sop_p2  <= 1'b0;
            eop_p2  <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                gray_p2 <= gray_k;
                sop_p2  <= sop_p1;
                eop_p2  <= eop_p1;
            end
        end
    end

    assign y_valid = vld_p2;
    assign y_data  = gray_p2;
    assign y_sop   = sop_p2;
    assign y_eop   = eop_p2;

    // Frame checking. pix_cnt==0 means no frame has been opened since reset;
    // 'closed' marks that the current frame already saw its EOP.
    always_comb begin
        cnt_next = pix_cnt;
        err_now  = 1'b0;
        if (x_sop) begin
            cnt_next = CNT_ONE;
            if (!closed && (pix_cnt != '0) && (pix_cnt < CNT_NPIX)) begin
                err_now = 1'b1;
            end
        end else begin
            if (pix_cnt != CNT_SAT) begin
                cnt_next = pix_cnt + CNT_ONE;
            end
            if ((pix_cnt == '0) || closed) begin
                err_now = 1'b1;
            end
        end
        if (x_eop && (cnt_next != CNT_NPIX)) begin
            err_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            closed      <= 1'b0;
            frame_count <= '0;
            frame_error <= 1'b0;
        end else if (x_acc) begin
            pix_cnt <= cnt_next;
            closed  <= x_eop | (closed & ~x_sop);
            if (x_eop) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
            if (err_now) begin
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Self-checking bench for rgb_gray_stream (4x2 image so framing is exercised).
// The driver pushes the expected output of every accepted pixel into a
// scoreboard queue; a monitor pops and compares whenever y_valid&y_ready.
module tb_rgb_gray_stream;

    localparam int CH_W       = 4;
    localparam int OUT_W      = 8;
    localparam int IMG_WIDTH  = 4;
    localparam int IMG_HEIGHT = 2;
    localparam int FCNT_W     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        x_valid;
    logic        x_ready;
    logic [11:0] x_data;
    logic        x_sop;
    logic        x_eop;
    logic        y_valid;
    logic        y_ready;
    logic [7:0]  y_data;
    logic        y_sop;
    logic        y_eop;
    logic [15:0] frame_count;
    logic        frame_error;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   cur_mode = 0;
    int   yr_ctl  = 1;        // 0: hold low, 1: always high, 2: random
    int   hold_until = 0;
    bit   done    = 0;
    bit   lat_chk = 0;
    bit   stall_seen = 0;

    rgb_gray_stream #(
        .CH_W       (CH_W),
        .OUT_W      (OUT_W),
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .FCNT_W     (FCNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .x_sop       (x_sop),
        .x_eop       (x_eop),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .y_data      (y_data),
        .y_sop       (y_sop),
        .y_eop       (y_eop),
        .frame_count (frame_count),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference: a 4-bit channel widened to 8 bits by replication equals c*17.
    function automatic logic [7:0] ref_gray(input logic [11:0] px, input int md);
        int r, g, b, v;
        r = int'(px[11:8]) * 17;
        g = int'(px[7:4]) * 17;
        b = int'(px[3:0]) * 17;
        case (md)
            0:       v = (r + g + b) / 3;
            1:       v = (77 * r + 150 * g + 29 * b) / 256;
            2:       v = g;
            default: begin
                v = r;
                if (g > v) v = g;
                if (b > v) v = b;
            end
        endcase
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] px, input bit sop, input bit eop,
                        input logic [1:0] md, input int exp_d = -1);
        bit   acc_done;
        exp_t e;
        acc_done = 0;
        if (sop) cur_mode = int'(md);
        x_data  = px;
        x_sop   = sop;
        x_eop   = eop;
        mode    = md;
        x_valid = 1'b1;
        for (int k = 0; k < 300 && !acc_done; k++) begin
            @(negedge clk);
            if (x_ready) begin
                e.d   = (exp_d >= 0) ? 8'(exp_d) : ref_gray(px, cur_mode);
                e.sop = sop;
                e.eop = eop;
                e.cyc = cyc;
                sb.push_back(e);
                acc_done = 1;
            end
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        if (!acc_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: pixel 0x%0h not accepted, required acceptance", px);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || y_valid) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        cur_mode = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'd0; x_valid = 1'b0; x_data = '0;
        x_sop = 1'b0; x_eop = 1'b0; y_ready = 1'b1;
        fork
            // ---------------- driver ----------------
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("rst_x_ready", x_ready, 0);
                check("rst_y_valid", y_valid, 0);
                check("rst_y_data", y_data, 0);
                check("rst_frame_count", frame_count, 0);
                check("rst_frame_error", frame_error, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;

                // Directed conversions, latency checked with y_ready high.
                yr_ctl = 1;
                lat_chk = 1;
                send(12'hFFF, 1, 0, 2'd0, 8'hFF);
                send(12'h840, 0, 0, 2'd0, 8'h44);
                send(12'h0F0, 1, 0, 2'd1, 8'h95);
                send(12'h3A5, 1, 0, 2'd2, 8'hAA);
                send(12'h3A5, 1, 0, 2'd3, 8'hAA);
                send(12'h000, 1, 0, 2'd3, 8'h00);
                drain();
                lat_chk = 0;

                // 20-pixel burst with y_ready held low mid-burst.
                stall_seen = 0;
                for (int i = 0; i < 20; i++) begin
                    if (i == 8) hold_until = cyc + 5;
                    send(12'($urandom), i == 0, i == 19, 2'($urandom_range(0, 3)));
                end
                drain();
                check("burst_stall_seen", stall_seen, 1);

                // Random traffic with random backpressure and mode changes.
                yr_ctl = 2;
                for (int i = 0; i < 300; i++) begin
                    send(12'($urandom), (i % 8) == 0, (i % 8) == 7, 2'($urandom_range(0, 3)));
                end
                yr_ctl = 1;
                drain();

                // Clean 4x2 frame: mode 0 at SOP, mode 1 on pixel 3 is ignored.
                do_reset();
                for (int i = 0; i < 8; i++) begin
                    send(12'($urandom), i == 0, i == 7,
                         (i == 0) ? 2'd0 : ((i == 2) ? 2'd1 : 2'($urandom_range(0, 3))));
                end
                drain();
                check("frame_ok_count", frame_count, 1);
                check("frame_ok_error", frame_error, 0);

                // Early EOP on pixel 6, then stray pixels, then a good frame.
                do_reset();
                for (int i = 0; i < 5; i++) send(12'($urandom), i == 0, 0, 2'd1);
                check("early_eop_err_before", frame_error, 0);
                send(12'($urandom), 0, 1, 2'd0);
                drain();
                check("early_eop_err", frame_error, 1);
                check("early_eop_count", frame_count, 1);
                send(12'($urandom), 0, 0, 2'd3);
                send(12'($urandom), 0, 0, 2'd3);
                for (int i = 0; i < 8; i++) send(12'($urandom), i == 0, i == 7, 2'd2);
                drain();
                check("after_err_count", frame_count, 2);
                check("after_err_sticky", frame_error, 1);

                // SOP arriving before the current frame is closed.
                do_reset();
                for (int i = 0; i < 3; i++) send(12'($urandom), i == 0, 0, 2'd3);
                check("mid_sop_err_before", frame_error, 0);
                send(12'($urandom), 1, 0, 2'd3);
                drain();
                check("mid_sop_err", frame_error, 1);

                // Non-SOP first pixel after reset; mode must be back to avg.
                do_reset();
                send(12'($urandom), 0, 0, 2'd2);
                drain();
                check("no_sop_err", frame_error, 1);

                // Reset with two pixels buffered.
                do_reset();
                for (int i = 0; i < 8; i++) send(12'($urandom), i == 0, i == 7, 2'd3);
                drain();
                check("pre_rst_count", frame_count, 1);
                yr_ctl = 0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                send(12'h123, 0, 0, 2'd0);
                send(12'h456, 1, 0, 2'd1);
                @(negedge clk);
                check("buf_y_valid", y_valid, 1);
                check("buf_x_ready", x_ready, 0);
                check("buf_frame_error", frame_error, 1);
                @(posedge clk); #1;
                rst_n = 1'b0;
                @(negedge clk);
                check("in_rst_x_ready", x_ready, 0);
                @(posedge clk);
                @(negedge clk);
                check("post_rst_y_valid", y_valid, 0);
                check("post_rst_frame_count", frame_count, 0);
                check("post_rst_frame_error", frame_error, 0);
                check("post_rst_x_ready", x_ready, 0);
                sb.delete();
                cur_mode = 0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                yr_ctl = 1;
                for (int i = 0; i < 8; i++) send(12'($urandom), i == 0, i == 7, 2'd1);
                drain();
                check("recover_count", frame_count, 1);
                check("recover_error", frame_error, 0);
                done = 1;
            end
            // ---------------- y_ready generator ----------------
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (cyc < hold_until || yr_ctl == 0) y_ready = 1'b0;
                    else if (yr_ctl == 2) y_ready = 1'($urandom_range(0, 1));
                    else y_ready = 1'b1;
                end
            end
            // ---------------- monitor ----------------
            begin : monitor
                logic       held;
                logic [9:0] hd;
                exp_t       e;
                held = 1'b0;
                hd   = '0;
                while (!done) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        held = 1'b0;
                        continue;
                    end
                    if (x_valid && !x_ready) stall_seen = 1;
                    if (held) begin
                        check("hold_y_valid", y_valid, 1);
                        check("hold_y_payload", {y_sop, y_eop, y_data}, hd);
                    end
                    if (y_valid && y_ready) begin
                        if (sb.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_output: got 0x%0h, expected no output", y_data);
                        end else begin
                            e = sb.pop_front();
                            check("y_data", y_data, e.d);
                            check("y_sop", y_sop, e.sop);
                            check("y_eop", y_eop, e.eop);
                            if (lat_chk) check("latency", cyc - e.cyc, 2);
                        end
                    end
                    held = y_valid && !y_ready;
                    hd   = {y_sop, y_eop, y_data};
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
